axi_wr_slave_mem: RTL and testbench

- Synthesizable AXI4-full write-channel slave with an internal byte-enabled memory.
- Next-generation replacement for the fixed-handshake write responder used around burst_axi. Adds parametrised width/depth, FIXED/INCR/WRAP bursts, WSTRB, programmable WREADY throttling, delayed BRESP, and protocol/range error reporting.
- Sits on the write side of burst_axi's M_AXI bus. A debug read port lets benches check stored data.

---
 rtl/axi_wr_slave_mem.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_wr_slave_mem.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_slave_mem.sv
`timescale 1ns/1ps
// axi_wr_slave_mem
// AXI4 write-channel slave backed by a byte-enabled memory. It accepts one
// write transaction at a time and supports FIXED, INCR and WRAP bursts.
// WREADY can be throttled with idle gaps between beats. The write response is
// issued a fixed number of cycles after the last beat.
//
// Ports:
//   M_AXI_ACLK / M_AXI_ARESETN : clock, asynchronous active-low reset
//   M_AXI_AW*                  : write address channel (ID, address, length,
//                                size, burst type, handshake)
//   M_AXI_W*                   : write data channel (data, strobes, last,
//                                handshake)
//   M_AXI_B*                   : write response channel (ID, response,
//                                handshake)
//   dbg_addr / dbg_data        : combinational read port into the memory
//   err_wlast                  : one-cycle pulse when WLAST disagrees with
//                                the beat count
module axi_wr_slave_mem #(
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WREADY_GAP  = 0,
  parameter int BRESP_DELAY = 2
) (
  input  logic                         M_AXI_ACLK,
  input  logic                         M_AXI_ARESETN,
  input  logic [ID_W-1:0]              M_AXI_AWID,
  input  logic [ADDR_W-1:0]            M_AXI_AWADDR,
  input  logic [7:0]                   M_AXI_AWLEN,
  input  logic [2:0]                   M_AXI_AWSIZE,
  input  logic [1:0]                   M_AXI_AWBURST,
  input  logic                         M_AXI_AWVALID,
  output logic                         M_AXI_AWREADY,
  input  logic [DATA_W-1:0]            M_AXI_WDATA,
  input  logic [DATA_W/8-1:0]          M_AXI_WSTRB,
  input  logic                         M_AXI_WLAST,
  input  logic                         M_AXI_WVALID,
  output logic                         M_AXI_WREADY,
  output logic [ID_W-1:0]              M_AXI_BID,
  output logic [1:0]                   M_AXI_BRESP,
  output logic                         M_AXI_BVALID,
  input  logic                         M_AXI_BREADY,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_W-1:0]            dbg_data,
  output logic                         err_wlast
);

  localparam int STRB_W     = DATA_W / 8;
  localparam int BYTE_SHIFT = $clog2(STRB_W);
  localparam int IDX_W      = $clog2(MEM_DEPTH);
  localparam int GAP_W      = (WREADY_GAP > 1) ? $clog2(WREADY_GAP) : 1;
  localparam int DLY_W      = (BRESP_DELAY > 2) ? $clog2(BRESP_DELAY - 1) : 1;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  typedef enum logic [2:0] {IDLE, AW_ACK, DATA, RESP_DLY, RESP} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  idx;
  logic [ADDR_W-1:0]  next_idx;
  logic [ADDR_W-1:0]  wrap_mask;
  logic [ADDR_W-1:0]  aw_idx;
  logic [7:0]         len;
  logic [7:0]         cnt;
  logic [1:0]         burst;
  logic [ID_W-1:0]    id;
  logic               slverr;
  logic               aw_err;
  logic [GAP_W-1:0]   gap_cnt;
  logic [DLY_W-1:0]   dly_cnt;

  logic               beat;
  logic               final_beat;
  logic               in_range;
  logic               wlast_err;
  logic               range_err;
  logic               mem_we;
  logic               slverr_nxt;
  logic               size_bad;
  logic               burst_bad;
  logic               wrap_len_bad;

  logic [DATA_W-1:0]  mem [MEM_DEPTH];

  // aw_err marks transactions whose beats must never touch memory; slverr
  // accumulates every reason the response ends up as SLVERR.
  always_comb begin
    beat         = (state == DATA) && M_AXI_WVALID && M_AXI_WREADY;
    final_beat   = (cnt == len);
    in_range     = (idx < ADDR_W'(MEM_DEPTH));
    wlast_err    = beat && (M_AXI_WLAST != final_beat);
    range_err    = beat && (!in_range || aw_err);
    mem_we       = beat && in_range && !aw_err;
    slverr_nxt   = slverr || wlast_err || range_err;
    aw_idx       = M_AXI_AWADDR >> BYTE_SHIFT;
    size_bad     = (M_AXI_AWSIZE != 3'(BYTE_SHIFT));
    burst_bad    = (M_AXI_AWBURST == BURST_RSVD);
    wrap_len_bad = (M_AXI_AWBURST == BURST_WRAP) &&
                   !((M_AXI_AWLEN == 8'd1) || (M_AXI_AWLEN == 8'd3) ||
                     (M_AXI_AWLEN == 8'd7) || (M_AXI_AWLEN == 8'd15));
  end

  // WRAP lengths are restricted to 2/4/8/16 beats, so len doubles as the
  // in-window offset mask and the window base is the index with those bits
  // cleared.
  always_comb begin
    wrap_mask = ADDR_W'(len);
    next_idx  = idx + 1'b1;
    case (burst)
      BURST_FIXED: next_idx = idx;
      BURST_WRAP:  next_idx = (idx & ~wrap_mask) | ((idx + 1'b1) & wrap_mask);
      default:     next_idx = idx + 1'b1;
    endcase
  end

  // Transaction FSM. All channel outputs are registered here. Reserved and
  // illegal-length WRAP bursts are recorded as INCR so the data phase still
  // walks a sensible address sequence.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      M_AXI_AWREADY <= 1'b0;
      M_AXI_WREADY  <= 1'b0;
      M_AXI_BVALID  <= 1'b0;
      M_AXI_BRESP   <= 2'd0;
      M_AXI_BID     <= '0;
      err_wlast     <= 1'b0;
      idx           <= '0;
      len           <= '0;
      cnt           <= '0;
      burst         <= BURST_FIXED;
      id            <= '0;
      slverr        <= 1'b0;
      aw_err        <= 1'b0;
      gap_cnt       <= '0;
      dly_cnt       <= '0;
    end else begin
      err_wlast <= wlast_err;
      case (state)
        IDLE: begin
          if (M_AXI_AWVALID) begin
            M_AXI_AWREADY <= 1'b1;
            state         <= AW_ACK;
          end
        end
        AW_ACK: begin
          M_AXI_AWREADY <= 1'b0;
          id            <= M_AXI_AWID;
          len           <= M_AXI_AWLEN;
          burst         <= (burst_bad || wrap_len_bad) ? BURST_INCR : M_AXI_AWBURST;
          idx           <= aw_idx;
          cnt           <= '0;
          aw_err        <= size_bad || burst_bad;
          slverr        <= size_bad || burst_bad || wrap_len_bad;
          gap_cnt       <= '0;
          M_AXI_WREADY  <= 1'b1;
          state         <= DATA;
        end
        DATA: begin
          if (beat) begin
            slverr <= slverr_nxt;
            idx    <= next_idx;
            cnt    <= cnt + 8'd1;
            if (final_beat) begin
              M_AXI_WREADY <= 1'b0;
              if (BRESP_DELAY <= 1) begin
                M_AXI_BVALID <= 1'b1;
                M_AXI_BID    <= id;
                M_AXI_BRESP  <= slverr_nxt ? 2'd2 : 2'd0;
                state        <= RESP;
              end else begin
                dly_cnt <= DLY_W'(BRESP_DELAY - 2);
                state   <= RESP_DLY;
              end
            end else if (WREADY_GAP > 0) begin
              M_AXI_WREADY <= 1'b0;
              gap_cnt      <= GAP_W'(WREADY_GAP - 1);
            end
          end else if (!M_AXI_WREADY) begin
            if (gap_cnt == '0) begin
              M_AXI_WREADY <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
        end
        RESP_DLY: begin
          if (dly_cnt == '0) begin
            M_AXI_BVALID <= 1'b1;
            M_AXI_BID    <= id;
            M_AXI_BRESP  <= slverr ? 2'd2 : 2'd0;
            state        <= RESP;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        RESP: begin
          if (M_AXI_BREADY) begin
            M_AXI_BVALID <= 1'b0;
            M_AXI_BRESP  <= 2'd0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge M_AXI_ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (M_AXI_WSTRB[b]) begin
          mem[idx[IDX_W-1:0]][8*b +: 8] <= M_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
`timescale 1ns/1ps
// tb_axi_wr_slave_mem
// Drives two slave instances, one with back-to-back WREADY and one with a
// two-cycle WREADY gap. Directed and random write bursts are used. Each
// observed value is compared against a behavioural model of the memory and
// of the response.
module tb_axi_wr_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [3:0]  aw_id;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        aw_valid;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic        w_valid;
  logic        b_ready;
  logic [7:0]  dbg_addr;

  logic        awready0, wready0, bvalid0, errw0;
  logic        awready2, wready2, bvalid2, errw2;
  logic [3:0]  bid0, bid2;
  logic [1:0]  bresp0, bresp2;
  logic [31:0] dbg0, dbg2;

  logic        awready, wready, bvalid, err_wlast;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic [31:0] dbg_data;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;

  logic [31:0] model_mem [2][256];
  logic        model_ok  [2][256];
  logic [31:0] beat_data [256];
  logic [3:0]  beat_strb [256];
  logic        beat_last [256];

  always #5 clk = ~clk;

  axi_wr_slave_mem #(
    .ID_W(4), .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256),
    .WREADY_GAP(0), .BRESP_DELAY(2)
  ) dut0 (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .M_AXI_AWID(aw_id), .M_AXI_AWADDR(aw_addr), .M_AXI_AWLEN(aw_len),
    .M_AXI_AWSIZE(aw_size), .M_AXI_AWBURST(aw_burst),
    .M_AXI_AWVALID(aw_valid & ~sel), .M_AXI_AWREADY(awready0),
    .M_AXI_WDATA(w_data), .M_AXI_WSTRB(w_strb), .M_AXI_WLAST(w_last),
    .M_AXI_WVALID(w_valid & ~sel), .M_AXI_WREADY(wready0),
    .M_AXI_BID(bid0), .M_AXI_BRESP(bresp0), .M_AXI_BVALID(bvalid0),
    .M_AXI_BREADY(b_ready & ~sel),
    .dbg_addr(dbg_addr), .dbg_data(dbg0), .err_wlast(errw0)
  );

  axi_wr_slave_mem #(
    .ID_W(4), .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256),
    .WREADY_GAP(2), .BRESP_DELAY(2)
  ) dut2 (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .M_AXI_AWID(aw_id), .M_AXI_AWADDR(aw_addr), .M_AXI_AWLEN(aw_len),
    .M_AXI_AWSIZE(aw_size), .M_AXI_AWBURST(aw_burst),
    .M_AXI_AWVALID(aw_valid & sel), .M_AXI_AWREADY(awready2),
    .M_AXI_WDATA(w_data), .M_AXI_WSTRB(w_strb), .M_AXI_WLAST(w_last),
    .M_AXI_WVALID(w_valid & sel), .M_AXI_WREADY(wready2),
    .M_AXI_BID(bid2), .M_AXI_BRESP(bresp2), .M_AXI_BVALID(bvalid2),
    .M_AXI_BREADY(b_ready & sel),
    .dbg_addr(dbg_addr), .dbg_data(dbg2), .err_wlast(errw2)
  );

  assign awready   = sel ? awready2 : awready0;
  assign wready    = sel ? wready2  : wready0;
  assign bvalid    = sel ? bvalid2  : bvalid0;
  assign bid       = sel ? bid2     : bid0;
  assign bresp     = sel ? bresp2   : bresp0;
  assign dbg_data  = sel ? dbg2     : dbg0;
  assign err_wlast = sel ? errw2    : errw0;

  // err_wlast pulses are counted on the clock so a single-cycle pulse is
  // seen exactly once.
  always @(posedge clk) begin
    if (err_wlast === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  // Word index of beat i. WRAP wraps inside a window of (len+1) words that is
  // aligned to its own size.
  function automatic longint beatIndex(input longint start, input int len,
                                       input logic [1:0] burst, input int i);
    longint span, base;
    if (burst == 2'd0) return start;
    if (burst == 2'd2) begin
      span = longint'(len + 1);
      base = (start / span) * span;
      return base + ((start - base + longint'(i)) % span);
    end
    return start + longint'(i);
  endfunction

  task automatic prepBeats(input int len);
    for (int i = 0; i < 256; i++) begin
      beat_data[i] = $urandom;
      beat_strb[i] = 4'hF;
      beat_last[i] = (i == len);
    end
  endtask

  // Runs one complete write transaction on the selected instance. It checks
  // the handshake timing, memory contents, err_wlast pulses and the response.
  task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst, input int hold);
    int n, gap, d, exp_pulses, pulses_before;
    longint start;
    logic [1:0] eff;
    logic aw_bad, err;
    logic [1:0] exp_resp;
    longint bidx [256];
    logic bwe [256];
    gap = sel ? 2 : 0;
    d = sel ? 1 : 0;
    start = longint'(addr >> 2);
    aw_bad = (size != 3'd2) || (burst == 2'd3);
    err = aw_bad;
    eff = (burst == 2'd3) ? 2'd1 : burst;
    if (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15)) begin
      err = 1'b1;
      eff = 2'd1;
    end
    exp_pulses = 0;
    for (int i = 0; i <= len; i++) begin
      bidx[i] = beatIndex(start, len, eff, i);
      bwe[i] = !aw_bad && (bidx[i] < 256);
      if (bidx[i] >= 256) err = 1'b1;
      if (beat_last[i] != (i == len)) begin
        err = 1'b1;
        exp_pulses++;
      end
    end
    exp_resp = err ? 2'd2 : 2'd0;

    @(negedge clk);
    aw_id = id; aw_addr = addr; aw_len = 8'(len); aw_size = size; aw_burst = burst;
    aw_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (awready !== 1'b1 && n < 20);
    checkOutput("awready_latency", n, 1);
    @(negedge clk);
    aw_valid = 1'b0;
    checkOutput("awready_pulse", awready, 0);
    pulses_before = pulse_cnt;

    for (int i = 0; i <= len; i++) begin
      w_data = beat_data[i]; w_strb = beat_strb[i]; w_last = beat_last[i]; w_valid = 1'b1;
      n = 0;
      while (wready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput("wready_gap", n, (i == 0) ? 0 : gap);
      if (bwe[i]) begin
        dbg_addr = 8'(bidx[i]);
        #1;
        if (model_ok[d][bidx[i]]) checkOutput("dbg_prewrite", dbg_data, model_mem[d][bidx[i]]);
        model_mem[d][bidx[i]] = mergeBytes(model_mem[d][bidx[i]], beat_data[i], beat_strb[i]);
        model_ok[d][bidx[i]] = 1'b1;
      end
      @(negedge clk);
      if (bwe[i]) checkOutput("dbg_postwrite", dbg_data, model_mem[d][bidx[i]]);
    end
    w_valid = 1'b0;
    w_last = 1'b0;
    checkOutput("wready_drop", wready, 0);
    checkOutput("bvalid_early", bvalid, 0);
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bvalid_latency", n, 1);
    checkOutput("err_wlast_pulses", pulse_cnt - pulses_before, exp_pulses);
    checkOutput("bresp", bresp, exp_resp);
    checkOutput("bid", bid, id);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("bvalid_hold", bvalid, 1);
      checkOutput("bresp_hold", bresp, exp_resp);
    end
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    checkOutput("bvalid_clear", bvalid, 0);
    checkOutput("awready_after_b", awready, 0);
    for (int i = 0; i <= len; i++) begin
      if (bidx[i] < 256 && model_ok[d][bidx[i]]) begin
        dbg_addr = 8'(bidx[i]);
        #1;
        checkOutput("mem_readback", dbg_data, model_mem[d][bidx[i]]);
      end
    end
  endtask

  task automatic randomBurst();
    int len;
    logic [1:0] burst;
    logic [2:0] size;
    burst = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    if (burst == 2'd2) len = (2 << $urandom_range(0, 3)) - 1;
    else len = $urandom_range(0, 15);
    size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
    prepBeats(len);
    for (int i = 0; i <= len; i++) beat_strb[i] = 4'($urandom);
    if ($urandom_range(0, 5) == 0) begin
      int k;
      k = $urandom_range(0, len);
      beat_last[k] = ~beat_last[k];
    end
    applyStimulus(4'($urandom), 32'($urandom_range(0, 1023)), len, size, burst,
                  $urandom_range(0, 3));
  endtask

  initial begin
    int wrap_order [4];
    rst_n = 1'b0; sel = 1'b0;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = 3'd2; aw_burst = 2'd1; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0; dbg_addr = '0;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 256; i++) model_ok[d][i] = 1'b0;
    wrap_order[0] = 6; wrap_order[1] = 7; wrap_order[2] = 4; wrap_order[3] = 5;

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = 1'(d);
      #1;
      checkOutput("rst_awready", awready, 0);
      checkOutput("rst_wready", wready, 0);
      checkOutput("rst_bvalid", bvalid, 0);
      checkOutput("rst_bresp", bresp, 0);
      checkOutput("rst_bid", bid, 0);
      checkOutput("rst_err_wlast", err_wlast, 0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Fill both memories with zeros using the longest possible burst.
    for (int d = 0; d < 2; d++) begin
      sel = 1'(d);
      prepBeats(255);
      for (int i = 0; i < 256; i++) beat_data[i] = '0;
      applyStimulus(4'h1, 32'h0, 255, 3'd2, 2'd1, 0);
    end

    sel = 1'b0;
    $display("[TB] directed bursts, back-to-back WREADY");
    prepBeats(3);
    for (int i = 0; i < 4; i++) beat_data[i] = 32'hA0 + 32'(i);
    applyStimulus(4'h5, 32'h10, 3, 3'd2, 2'd1, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 8'(4 + i);
      #1;
      checkOutput("incr_word", dbg_data, 32'hA0 + 32'(i));
    end

    prepBeats(3);
    applyStimulus(4'h3, 32'h18, 3, 3'd2, 2'd2, 1);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 8'(wrap_order[i]);
      #1;
      checkOutput("wrap_word", dbg_data, beat_data[i]);
    end

    prepBeats(2);
    beat_data[0] = 32'h11;     beat_strb[0] = 4'h1;
    beat_data[1] = 32'h2200;   beat_strb[1] = 4'h2;
    beat_data[2] = 32'h330000; beat_strb[2] = 4'h4;
    applyStimulus(4'h2, 32'h0, 2, 3'd2, 2'd0, 0);
    dbg_addr = 8'd0;
    #1;
    checkOutput("fixed_merge", dbg_data, 32'h00332211);

    prepBeats(3);
    beat_last[1] = 1'b1;
    applyStimulus(4'h6, 32'h80, 3, 3'd2, 2'd1, 2);

    prepBeats(1);
    applyStimulus(4'h7, 32'(255 * 4), 1, 3'd2, 2'd1, 0);
    dbg_addr = 8'd255;
    #1;
    checkOutput("top_word", dbg_data, beat_data[0]);

    prepBeats(1);
    applyStimulus(4'h8, 32'h20, 1, 3'd1, 2'd1, 0);

    for (int r = 0; r < 12; r++) randomBurst();

    sel = 1'b1;
    $display("[TB] directed bursts, gapped WREADY");
    prepBeats(3);
    applyStimulus(4'h9, 32'h100, 3, 3'd2, 2'd1, 5);

    // Reset in the middle of a data phase: one beat lands, then the burst is
    // abandoned and every output must be cleared at once.
    @(negedge clk);
    aw_id = 4'hC; aw_addr = 32'h40; aw_len = 8'd3; aw_size = 3'd2; aw_burst = 2'd1;
    aw_valid = 1'b1;
    for (int n = 0; n < 20 && awready !== 1'b1; n++) @(negedge clk);
    @(negedge clk);
    aw_valid = 1'b0;
    w_data = 32'hDEADBEEF; w_strb = 4'hF; w_last = 1'b0; w_valid = 1'b1;
    checkOutput("mid_first_wready", wready, 1);
    @(negedge clk);
    w_valid = 1'b0;
    model_mem[1][16] = 32'hDEADBEEF;
    model_ok[1][16] = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_awready", awready, 0);
    checkOutput("midrst_wready", wready, 0);
    checkOutput("midrst_bvalid", bvalid, 0);
    checkOutput("midrst_bresp", bresp, 0);
    checkOutput("midrst_bid", bid, 0);
    checkOutput("midrst_err_wlast", err_wlast, 0);
    dbg_addr = 8'd16;
    #1;
    checkOutput("midrst_mem_kept", dbg_data, 32'hDEADBEEF);
    @(negedge clk);
    rst_n = 1'b1;

    prepBeats(3);
    applyStimulus(4'hA, 32'h44, 3, 3'd2, 2'd1, 1);

    for (int r = 0; r < 6; r++) randomBurst();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
